uart_tx_controller: RTL

Frame sequencer for the UART transmit path. Accepts one byte at a time over a valid/ready handshake and serialises it onto the `tx` line: start bit, data LSB-first, optional parity, stop bit(s). It advances exactly one bit per `tx_en` pulse from the baud rate generator. It owns no baud counter; bit timing comes entirely from `tx_en`.

---
 rtl/uart_tx_controller_if.sv | 21 ++
 rtl/uart_tx_controller.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_controller_if.sv
// Byte handshake between a producer and the UART transmit sequencer.
// The producer drives data_in/data_valid; the sequencer answers with data_ready.
interface uart_tx_controller_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/uart_tx_controller.sv
// UART transmit frame sequencer: start, data LSB-first, optional even parity, stop bit(s).
// One bit per tx_en pulse. Define UART_TX_PARITY_EN to compile in the parity bit.
module uart_tx_controller #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_en,
  uart_tx_controller_if.slave host,
  output logic                tx,
  output logic                busy
);

  localparam int unsigned     CntW     = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastBit  = CntW'(DATA_WIDTH - 1);
  localparam logic            LastStop = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  tx_q, tx_d;
  logic                  ready_q, ready_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    unique case (state_q)
      // tx_en is ignored here, so a tick coinciding with accept is not consumed.
      StIdle: begin
        if (host.data_valid && ready_q) begin
          shift_d = host.data_in;
          ready_d = 1'b0;
          state_d = StArm;
`ifdef UART_TX_PARITY_EN
          parity_d = ^host.data_in;
`endif
        end
      end
      StArm: begin
        if (tx_en) begin
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tx_en) begin
          tx_d    = shift_q[0];
          cnt_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (tx_en) begin
          if (cnt_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = StParity;
`else
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = StStop;
`endif
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (tx_en) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = StStop;
        end
      end
`endif
      StStop: begin
        if (tx_en) begin
          if (stop_cnt_q == LastStop) begin
            ready_d = 1'b1;
            state_d = StIdle;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign tx              = tx_q;
  assign busy            = (state_q != StIdle);
  assign host.data_ready = ready_q;

endmodule
